// File: rtl/sram_dual_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM macro between requesters A and B.
// Optional grant/conflict statistics counters are enabled with `define SRAM_ARB_STATS_EN.
module sram_dual_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int RD_LATENCY = 1,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,
`ifdef SRAM_ARB_STATS_EN
    input  logic                  stats_clr,
    output logic [STAT_WIDTH-1:0] a_grant_cnt,
    output logic [STAT_WIDTH-1:0] b_grant_cnt,
    output logic [STAT_WIDTH-1:0] conflict_cnt,
`endif
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam int TAG_DEPTH = 1 + RD_LATENCY;

    // rr_reg = 0 prefers A on contention, 1 prefers B
    logic                  rr_reg, rr_next;
    logic                  contention;
    logic                  grant_a, grant_b;
    logic                  hs_a, hs_b, hs_any, hs_we;
    logic [ADDR_WIDTH-1:0] hs_addr;
    logic [DATA_WIDTH-1:0] hs_wdata;
    logic [TAG_DEPTH-1:0]  tag_valid_reg;
    logic [TAG_DEPTH-1:0]  tag_owner_reg;   // 1 = B owns the read

    always_comb begin
        contention  = a_req_valid & b_req_valid;
        grant_a     = a_req_valid & (~b_req_valid | ~rr_reg);
        grant_b     = b_req_valid & (~a_req_valid | rr_reg);
        a_req_ready = grant_a & ~rst0;
        b_req_ready = grant_b & ~rst0;
        hs_a        = a_req_valid & a_req_ready;
        hs_b        = b_req_valid & b_req_ready;
        hs_any      = hs_a | hs_b;
        hs_we       = hs_b ? b_req_we    : a_req_we;
        hs_addr     = hs_b ? b_req_addr  : a_req_addr;
        hs_wdata    = hs_b ? b_req_wdata : a_req_wdata;
        rr_next     = rr_reg;
        // After contention the loser becomes preferred
        if (contention && !rst0) begin
            rr_next = grant_a;
        end
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            rr_reg <= 1'b0;
            csb0   <= 1'b1;
            web0   <= 1'b1;
            addr0  <= '0;
            din0   <= '0;
        end else begin
            rr_reg <= rr_next;
            csb0   <= ~hs_any;
            web0   <= ~(hs_any & hs_we);
            if (hs_any) begin
                addr0 <= hs_addr;
                din0  <= hs_wdata;
            end
        end
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            tag_valid_reg <= '0;
            tag_owner_reg <= '0;
        end else begin
            tag_valid_reg[0] <= hs_any & ~hs_we;
            tag_owner_reg[0] <= hs_b;
            for (int i = 1; i < TAG_DEPTH; i++) begin
                tag_valid_reg[i] <= tag_valid_reg[i-1];
                tag_owner_reg[i] <= tag_owner_reg[i-1];
            end
        end
    end

    // The oldest tag lines up with the macro's read data
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            a_rsp_rdata <= '0;
            b_rsp_rdata <= '0;
        end else begin
            a_rsp_valid <= tag_valid_reg[RD_LATENCY] & ~tag_owner_reg[RD_LATENCY];
            b_rsp_valid <= tag_valid_reg[RD_LATENCY] &  tag_owner_reg[RD_LATENCY];
            if (tag_valid_reg[RD_LATENCY] && !tag_owner_reg[RD_LATENCY]) begin
                a_rsp_rdata <= dout0;
            end
            if (tag_valid_reg[RD_LATENCY] && tag_owner_reg[RD_LATENCY]) begin
                b_rsp_rdata <= dout0;
            end
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic [2:0] stat_inc;

    always_comb begin
        stat_inc[0] = hs_a;
        stat_inc[1] = hs_b;
        stat_inc[2] = contention & ~rst0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gen_stat
            logic [STAT_WIDTH-1:0] cnt_reg;
            // Clear wins over a coincident increment; counters stick at all-ones
            always_ff @(posedge clk0 or posedge rst0) begin
                if (rst0) begin
                    cnt_reg <= '0;
                end else if (stats_clr) begin
                    cnt_reg <= '0;
                end else if (stat_inc[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign a_grant_cnt  = gen_stat[0].cnt_reg;
    assign b_grant_cnt  = gen_stat[1].cnt_reg;
    assign conflict_cnt = gen_stat[2].cnt_reg;
`endif

endmodule

// File: tb/tb_sram_dual_port_arbiter.sv
// Scoreboard bench for sram_dual_port_arbiter with a behavioural single-port SRAM (1-cycle read).
// Stats checks are compiled in when SRAM_ARB_STATS_EN is defined.
module tb_sram_dual_port_arbiter;

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [31:0] data;   // write data, or expected read data
    } cmd_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk0 = 1'b0;
    logic        rst0;
    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
    logic [6:0]  a_req_addr;
    logic [31:0] a_req_wdata, a_rsp_rdata;
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
    logic [6:0]  b_req_addr;
    logic [31:0] b_req_wdata, b_rsp_rdata;
    logic        csb0, web0;
    logic [6:0]  addr0;
    logic [31:0] din0, dout0;
`ifdef SRAM_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] a_grant_cnt, b_grant_cnt, conflict_cnt;
`endif

    cmd_t a_q[$];
    cmd_t b_q[$];
    exp_t exp_a[$];
    exp_t exp_b[$];
    byte  grant_log[$];
    int   cycle = 0;
    int   a_acc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] mem [0:127];

    always #5 clk0 = ~clk0;

    sram_dual_port_arbiter dut (
        .clk0(clk0), .rst0(rst0),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
`ifdef SRAM_ARB_STATS_EN
        .stats_clr(stats_clr), .a_grant_cnt(a_grant_cnt),
        .b_grant_cnt(b_grant_cnt), .conflict_cnt(conflict_cnt),
`endif
        .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
    );

    // Macro model: samples registered pins on the rising edge, read data one cycle later
    always @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) mem[addr0] <= din0;
            else       dout0 <= mem[addr0];
        end
    end

    always @(posedge clk0) cycle <= cycle + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic push_a(input logic we, input logic [6:0] addr, input logic [31:0] data);
        cmd_t c;
        c.we = we; c.addr = addr; c.data = data;
        a_q.push_back(c);
    endtask

    task automatic push_b(input logic we, input logic [6:0] addr, input logic [31:0] data);
        cmd_t c;
        c.we = we; c.addr = addr; c.data = data;
        b_q.push_back(c);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((a_q.size() + b_q.size() + exp_a.size() + exp_b.size()) != 0 && k < 300) begin
            @(posedge clk0);
            k++;
        end
        if (k >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: pending a_q=%0d b_q=%0d exp_a=%0d exp_b=%0d",
                     a_q.size(), b_q.size(), exp_a.size(), exp_b.size());
            a_q.delete(); b_q.delete(); exp_a.delete(); exp_b.delete();
        end
        repeat (3) @(posedge clk0);
        #2;
    endtask

    // Driver: present queue heads after each edge, record handshakes before the next edge
    initial begin
        exp_t e;
        a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0;
        forever begin
            @(posedge clk0);
            #1;
            a_req_valid = (a_q.size() != 0);
            if (a_req_valid) begin
                a_req_we = a_q[0].we; a_req_addr = a_q[0].addr; a_req_wdata = a_q[0].data;
            end
            b_req_valid = (b_q.size() != 0);
            if (b_req_valid) begin
                b_req_we = b_q[0].we; b_req_addr = b_q[0].addr; b_req_wdata = b_q[0].data;
            end
            @(negedge clk0);
            if (a_req_valid && a_req_ready) begin
                $display("cyc %0d A %s addr %0d data %h", cycle, a_req_we ? "wr" : "rd", a_req_addr, a_req_wdata);
                if (!a_req_we) begin
                    e.data = a_req_wdata; e.due = cycle + 3;
                    exp_a.push_back(e);
                end
                void'(a_q.pop_front());
                grant_log.push_back(8'h41);
                a_acc++;
            end
            if (b_req_valid && b_req_ready) begin
                $display("cyc %0d B %s addr %0d data %h", cycle, b_req_we ? "wr" : "rd", b_req_addr, b_req_wdata);
                if (!b_req_we) begin
                    e.data = b_req_wdata; e.due = cycle + 3;
                    exp_b.push_back(e);
                end
                void'(b_q.pop_front());
                grant_log.push_back(8'h42);
            end
        end
    end

    // Monitor: pop and compare on every response pulse
    always @(negedge clk0) begin
        exp_t e;
        if (a_rsp_valid) begin
            n_cmp++;
            if (exp_a.size() == 0) begin
                n_err++;
                $display("FAIL a_rsp_unexpected: got %h at cyc %0d, want no response", a_rsp_rdata, cycle);
            end else begin
                e = exp_a.pop_front();
                $display("cyc %0d A rsp %h", cycle, a_rsp_rdata);
                if (a_rsp_rdata !== e.data || cycle != e.due) begin
                    n_err++;
                    $display("FAIL a_rsp: got %h at cyc %0d, want %h at cyc %0d", a_rsp_rdata, cycle, e.data, e.due);
                end
            end
        end
        if (b_rsp_valid) begin
            n_cmp++;
            if (exp_b.size() == 0) begin
                n_err++;
                $display("FAIL b_rsp_unexpected: got %h at cyc %0d, want no response", b_rsp_rdata, cycle);
            end else begin
                e = exp_b.pop_front();
                $display("cyc %0d B rsp %h", cycle, b_rsp_rdata);
                if (b_rsp_rdata !== e.data || cycle != e.due) begin
                    n_err++;
                    $display("FAIL b_rsp: got %h at cyc %0d, want %h at cyc %0d", b_rsp_rdata, cycle, e.data, e.due);
                end
            end
        end
    end

    initial begin
        string order;
        int    n, k;
        order = "ABABABAB";
        rst0 = 1'b1;
`ifdef SRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(posedge clk0);
        #2;
        chk("rst_csb0", {31'd0, csb0}, 32'd1);
        chk("rst_web0", {31'd0, web0}, 32'd1);
        chk("rst_addr0", {25'd0, addr0}, 32'd0);
        chk("rst_din0", din0, 32'd0);
        chk("rst_rsp_valid", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
        chk("rst_a_rdata", a_rsp_rdata, 32'd0);
        chk("rst_b_rdata", b_rsp_rdata, 32'd0);

        // Request held during reset must not be accepted
        push_a(1'b1, 7'd10, 32'hFACECAFE);
        repeat (2) @(posedge clk0);
        #2;
        chk("ready_in_rst", {31'd0, a_req_ready}, 32'd0);
        chk("acc_in_rst", a_acc, 0);
        rst0 = 1'b0;
        push_a(1'b0, 7'd10, 32'hFACECAFE);
        wait_idle();

        // Contention: alternating grants from an A-preferred pointer
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            push_a(1'b1, 7'(20 + i), 32'h11111111 * (i + 1));
            push_b(1'b1, 7'(40 + i), 32'h11111111 * (i + 5));
        end
        wait_idle();
        chk("grant_count", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            chk("grant_order", {24'd0, grant_log[i]}, {24'd0, order[i]});
        end
        for (int i = 0; i < 4; i++) begin
            push_a(1'b0, 7'(20 + i), 32'h11111111 * (i + 1));
            push_b(1'b0, 7'(40 + i), 32'h11111111 * (i + 5));
        end
        wait_idle();

        // Back-to-back reads from different owners must not swap
        push_b(1'b1, 7'd20, 32'hDEADBEEF);
        wait_idle();
        push_a(1'b0, 7'd10, 32'hFACECAFE);
        push_b(1'b0, 7'd20, 32'hDEADBEEF);
        wait_idle();

        // Write immediately followed by read of the same word
        push_b(1'b1, 7'd5, 32'h12345678);
        push_b(1'b0, 7'd5, 32'h12345678);
        wait_idle();

        // Reset while two reads are in flight
        n = a_acc;
        push_a(1'b0, 7'd10, 32'hFACECAFE);
        push_a(1'b0, 7'd10, 32'hFACECAFE);
        k = 0;
        while (a_acc < n + 2 && k < 50) begin
            @(negedge clk0);
            #1;
            k++;
        end
        chk("inflight_accepts", a_acc, n + 2);
        @(posedge clk0);
        #2;
        rst0 = 1'b1;
        exp_a.delete();
        exp_b.delete();
        a_q.delete();
        #1;
        chk("midrst_csb0", {31'd0, csb0}, 32'd1);
        chk("midrst_a_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("midrst_b_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
        repeat (2) @(posedge clk0);
        #2;
        rst0 = 1'b0;
        repeat (6) @(posedge clk0);
        #2;
        push_a(1'b0, 7'd10, 32'hFACECAFE);
        wait_idle();

`ifdef SRAM_ARB_STATS_EN
        rst0 = 1'b1;
        @(posedge clk0);
        #2;
        rst0 = 1'b0;
        chk("stat_rst_a", {16'd0, a_grant_cnt}, 32'd0);
        push_a(1'b1, 7'd100, 32'h00000001);
        push_a(1'b1, 7'd101, 32'h00000002);
        push_b(1'b1, 7'd102, 32'h00000003);
        wait_idle();
        push_a(1'b1, 7'd103, 32'h00000004);
        wait_idle();
        push_b(1'b1, 7'd104, 32'h00000005);
        wait_idle();
        chk("stat_a_grants", {16'd0, a_grant_cnt}, 32'd3);
        chk("stat_b_grants", {16'd0, b_grant_cnt}, 32'd2);
        chk("stat_conflicts", {16'd0, conflict_cnt}, 32'd2);
        stats_clr = 1'b1;
        @(posedge clk0);
        #2;
        stats_clr = 1'b0;
        chk("stat_clr_a", {16'd0, a_grant_cnt}, 32'd0);
        chk("stat_clr_b", {16'd0, b_grant_cnt}, 32'd0);
        chk("stat_clr_conf", {16'd0, conflict_cnt}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_dual_port_arbiter.md
Name: sram_dual_port_arbiter

Overview:
- Shares the single-port synchronous SRAM macro (32-bit x 128, ports csb0/web0/addr0/din0/dout0) between two requesters, A and B.
- Each requester has a valid/ready request channel and a fixed-latency read response channel.
- Arbitration is round-robin. Macro control pins are registered; one macro access per cycle, fully pipelined.
- Sits between the two bus masters and the SRAM macro instance.

Parameters:
- DATA_WIDTH, 32, data word width (matches macro).
- ADDR_WIDTH, 7, address width (RAM_DEPTH = 1<<ADDR_WIDTH = 128).
- RD_LATENCY, 1, macro cycles from sampled read command to valid dout0 (1..4).
- STAT_WIDTH, 16, width of grant statistics counters (optional feature only).

Ports:
- clk0  in  1  clock; all logic on rising edge.
- rst0  in  1  asynchronous active-high reset.
- a_req_valid  in  1  requester A command valid.
- a_req_ready  out  1  requester A command accepted this cycle.
- a_req_we  in  1  1 = write, 0 = read.
- a_req_addr  in  ADDR_WIDTH  word address.
- a_req_wdata  in  DATA_WIDTH  write data.
- a_rsp_valid  out  1  one-cycle pulse: read data valid for A.
- a_rsp_rdata  out  DATA_WIDTH  read data for A.
- b_req_valid, b_req_ready, b_req_we, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_rdata: same as A, for requester B.
- csb0  out  1  macro chip select, active low.
- web0  out  1  macro write enable, active low.
- addr0  out  ADDR_WIDTH  macro address.
- din0  out  DATA_WIDTH  macro write data.
- dout0  in  DATA_WIDTH  macro read data.

Behaviour:
- Reset (async, immediate) drives:
  - csb0=1, web0=1, addr0=0, din0=0.
  - a/b_rsp_valid=0, a/b_rsp_rdata=0.
  - RR pointer = A-preferred.
  - Read tag pipeline cleared.
  - a/b_req_ready=0 while rst0 high.
- Arbitration (combinational, each cycle):
  - Only one valid → that requester is granted.
  - Both valid → the requester named by the RR pointer is granted.
  - req_ready is asserted to the granted requester only. Handshake = valid & ready.
  - The RR pointer flips to the non-granted requester only when both were valid (contention); otherwise unchanged.
- Issue (edge T, handshake at T):
  - csb0<=0; web0<=~we; addr0<=addr; din0<=wdata.
  - No handshake → csb0<=1, web0<=1; addr0/din0 hold their previous values.
  - The macro samples the registered pins at edge T+1.
- Read return:
  - A tag {valid, owner} enters a shift pipeline of depth 1+RD_LATENCY at edge T.
  - At edge T+1+RD_LATENCY the controller captures dout0 into the owner's rsp_rdata and pulses that rsp_valid for exactly one cycle.
  - Default read latency = 2 cycles from accept to rsp_valid.
  - No response backpressure; requesters must sink responses.
  - rsp_rdata holds its last value when rsp_valid=0.
- Writes produce no response. A write at edge T followed by a read of the same address at T+1 returns the new data (macro ordering preserved, no bypass needed).
- Throughput: one access per cycle sustained; back-to-back accepts allowed from the same or alternating requesters.
- Simultaneous contention, both valid for N cycles: grants alternate A,B,A,B… starting from the pointer.
- Reset mid-operation:
  - In-flight read tags are discarded; no rsp_valid is produced after reset deasserts.
  - The macro sees csb0=1 immediately.
- Address wrap: addresses are used as-is (0..127). No bounds logic is needed.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs a_grant_cnt, b_grant_cnt and conflict_cnt, each STAT_WIDTH wide.
  - Grant counters count accepted commands per requester; conflict_cnt counts cycles with both valid.
  - All counters saturate at all-ones and reset to 0 on rst0.
  - Adds input stats_clr (1 bit), which synchronously zeroes all counters. If stats_clr coincides with an increment, the counter becomes 0.
- Undefined: the ports and counters are absent; the core behaviour is identical.

Test Plan:
- A writes addr 10 = 0xFACECAFE, then A reads addr 10 → a_rsp_valid exactly 2 cycles after the read accept, a_rsp_rdata=0xFACECAFE; b_rsp_valid stays 0.
- A and B both valid for 4 cycles: A writes addr 20..23 with 0x11111111.., B writes addr 40..43 → grants alternate A,B,A,B; after B's last accept both are granted their remaining ops; readback of all 8 addresses is correct.
- Back-to-back reads: A reads 10 and B reads 20 on consecutive cycles (20 preloaded with 0xDEADBEEF) → a_rsp_valid then b_rsp_valid on consecutive cycles with the correct data; the responses do not swap.
- Write-then-read hazard: B writes addr 5=0x12345678 at T, reads addr 5 at T+1 → b_rsp_rdata=0x12345678.
- Reset during an in-flight read: assert rst0 one cycle after the read accept → csb0=1 and all rsp_valid=0 immediately; no response after deassert; a subsequent read works.
- With SRAM_ARB_STATS_EN: 3 A grants, 2 B grants, 2 conflict cycles → counts 3/2/2; stats_clr → 0/0/0.
